// File: rtl/definitions_pkg.sv
// Shared arithmetic-unit types plus the sequential divider's state encoding,
// iteration count and magnitude helpers.
package definitions_pkg;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [15:0] int16_t;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIX,
        DONE
    } div_state_t;

    localparam int DIV_ITER = 16;

    // |-32768| comes out as 16'h8000 = 32768, read as unsigned.
    function automatic logic [15:0] abs16(input int16_t v);
        logic [15:0] u;
        u = v;
        return v[15] ? (~u + 16'd1) : u;
    endfunction

    // |-128| comes out as 8'h80 = 128, read as unsigned.
    function automatic logic [7:0] abs8(input int8_t v);
        logic [7:0] u;
        u = v;
        return v[7] ? (~u + 8'd1) : u;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/operand/result bundle of the sequential divider.
interface seq_divider_if;
    import definitions_pkg::*;

    logic   i_start;
    int16_t i_dvd;
    int8_t  i_dvs;
    logic   o_busy;
    logic   o_done;
    int8_t  o_quot;
    int8_t  o_rem;
    logic   o_ovf;
    logic   o_dz;

    modport master (
        output i_start, i_dvd, i_dvs,
        input  o_busy, o_done, o_quot, o_rem, o_ovf, o_dz
    );

    modport slave (
        input  i_start, i_dvd, i_dvs,
        output o_busy, o_done, o_quot, o_rem, o_ovf, o_dz
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring iteration on magnitudes: shift {rem, q} left,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step (
    input  logic [8:0]  rem,
    input  logic [15:0] q,
    input  logic [8:0]  dvs,
    output logic [8:0]  rem_next,
    output logic [15:0] q_next
);
    logic [9:0]  rem_sh;
    logic [9:0]  trial;
    logic [15:0] q_sh;

    // One extra bit so the borrow is a clean sign even for the widest remainder.
    assign rem_sh = {rem, q[15]};
    assign trial  = rem_sh - {1'b0, dvs};

    assign q_sh[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_qshift
            assign q_sh[gi] = q[gi-1];
        end
    endgenerate

    always_comb begin
        rem_next = rem_sh[8:0];
        q_next   = q_sh;
        if (!trial[9]) begin
            rem_next = trial[8:0];
            q_next   = {q_sh[15:1], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider, int16 / int8 -> int8 quotient and remainder,
// one quotient bit per clock, followed by a sign/overflow fix-up cycle.
module seq_divider
    import definitions_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    div_state_t  state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] q_reg, q_next;
    logic [8:0]  prem_reg, prem_next;
    logic [8:0]  dvs_reg, dvs_next;
    logic        qsign_reg, qsign_next;
    logic        rsign_reg, rsign_next;
    int8_t       quot_reg, quot_next;
    int8_t       rem_reg, rem_next;
    logic        ovf_reg, ovf_next;
    logic        dz_reg, dz_next;

    logic [8:0]  step_rem;
    logic [15:0] step_q;
    logic        ovf_cond;

    div_step u_step (
        .rem      (prem_reg),
        .q        (q_reg),
        .dvs      (dvs_reg),
        .rem_next (step_rem),
        .q_next   (step_q)
    );

    // -128 is the one magnitude above 127 that still fits.
    assign ovf_cond = (q_reg > 16'd127) && !((q_reg == 16'd128) && qsign_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            q_reg     <= '0;
            prem_reg  <= '0;
            dvs_reg   <= '0;
            qsign_reg <= 1'b0;
            rsign_reg <= 1'b0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            ovf_reg   <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            prem_reg  <= prem_next;
            dvs_reg   <= dvs_next;
            qsign_reg <= qsign_next;
            rsign_reg <= rsign_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            ovf_reg   <= ovf_next;
            dz_reg    <= dz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        prem_next  = prem_reg;
        dvs_next   = dvs_reg;
        qsign_next = qsign_reg;
        rsign_next = rsign_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        ovf_next   = ovf_reg;
        dz_next    = dz_reg;

        case (state_reg)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_dvs == 8'sd0) begin
                        dz_next    = 1'b1;
                        ovf_next   = 1'b0;
                        quot_next  = '0;
                        rem_next   = '0;
                        state_next = DONE;
                    end else begin
                        q_next     = abs16(bus.i_dvd);
                        dvs_next   = {1'b0, abs8(bus.i_dvs)};
                        prem_next  = '0;
                        qsign_next = bus.i_dvd[15] ^ bus.i_dvs[7];
                        rsign_next = bus.i_dvd[15];
                        ovf_next   = 1'b0;
                        dz_next    = 1'b0;
                        cnt_next   = '0;
                        state_next = DIVIDE;
                    end
                end
            end

            DIVIDE: begin
                prem_next = step_rem;
                q_next    = step_q;
                cnt_next  = cnt_reg + 4'd1;
                if (cnt_reg == 4'(DIV_ITER - 1)) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                if (ovf_cond) begin
                    ovf_next  = 1'b1;
                    quot_next = '0;
                    rem_next  = '0;
                end else begin
                    quot_next = qsign_reg ? (8'd0 - q_reg[7:0])    : q_reg[7:0];
                    rem_next  = rsign_reg ? (8'd0 - prem_reg[7:0]) : prem_reg[7:0];
                end
                state_next = DONE;
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.o_busy = (state_reg == DIVIDE) || (state_reg == FIX);
    assign bus.o_done = (state_reg == DONE);
    assign bus.o_quot = quot_reg;
    assign bus.o_rem  = rem_reg;
    assign bus.o_ovf  = ovf_reg;
    assign bus.o_dz   = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signs, overflow edges, divide-by-zero,
// held start with late input changes, and mid-operation reset.
module tb_seq_divider;
    import definitions_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    seq_divider_if dif ();

    seq_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one division at the next edge (cycle 0), then watch cycles 1..22.
    task automatic do_op(input string name, input int dvd, input int dvs,
                         input int eq, input int er, input int eovf, input int edz);
        int   done_k, done_n, busy_n, busy_out;
        int   sq, sr, sovf, sdz;
        int   exp_done_k, exp_busy;
        done_k = -1; done_n = 0; busy_n = 0; busy_out = 0;
        sq = 0; sr = 0; sovf = 0; sdz = 0;
        exp_done_k = edz ? 1 : 18;
        exp_busy   = edz ? 0 : 17;
        @(negedge clk);
        dif.i_start = 1'b1;
        dif.i_dvd   = 16'(dvd);
        dif.i_dvs   = 8'(dvs);
        @(posedge clk);
        #1;
        dif.i_start = 1'b0;
        dif.i_dvd   = 16'($urandom);
        dif.i_dvs   = 8'($urandom);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (dif.o_busy === 1'b1) begin
                if (k <= 17) busy_n++;
                else busy_out++;
            end
            if (dif.o_done === 1'b1) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    sq = int'(dif.o_quot); sr = int'(dif.o_rem);
                    sovf = int'(dif.o_ovf); sdz = int'(dif.o_dz);
                end
            end
        end
        chk({name, " done_cycle"}, done_k, exp_done_k);
        chk({name, " done_pulses"}, done_n, 1);
        chk({name, " busy_cycles"}, busy_n, exp_busy);
        chk({name, " busy_outside"}, busy_out, 0);
        chk({name, " quot"}, sq, eq);
        chk({name, " rem"}, sr, er);
        chk({name, " ovf"}, sovf, eovf);
        chk({name, " dz"}, sdz, edz);
        chk({name, " quot_held"}, int'(dif.o_quot), eq);
        $display("op %s: %0d / %0d -> quot=%0d rem=%0d ovf=%0d dz=%0d done@%0d",
                 name, dvd, dvs, sq, sr, sovf, sdz, done_k);
    endtask

    initial begin
        int d1, d2, busy_n, nd;
        int q1, r1, q2, r2;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        dif.i_start = 1'b0;
        dif.i_dvd   = '0;
        dif.i_dvs   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(dif.o_busy), 0);
        chk("reset done", int'(dif.o_done), 0);
        chk("reset quot", int'(dif.o_quot), 0);
        chk("reset rem",  int'(dif.o_rem), 0);
        chk("reset ovf",  int'(dif.o_ovf), 0);
        chk("reset dz",   int'(dif.o_dz), 0);
        $display("reset: outputs checked");
        rst = 1'b0;

        do_op("pos_pos",   100,    7,    14,  2, 0, 0);
        do_op("neg_pos",  -100,    7,   -14, -2, 0, 0);
        do_op("pos_neg",   100,   -7,   -14,  2, 0, 0);
        do_op("neg_neg",  -100,   -7,    14, -2, 0, 0);
        do_op("min_q",   16384, -128,  -128,  0, 0, 0);
        do_op("ovf_256", -32768, -128,    0,  0, 1, 0);
        do_op("ovf_333",  1000,    3,     0,  0, 1, 0);
        do_op("div_zero",   55,    0,     0,  0, 0, 1);

        // Start held high: 20/3 runs once, inputs changed in cycle 5 are ignored,
        // and the re-start in cycle 19 picks up the new 100/7.
        d1 = -1; d2 = -1; busy_n = 0; nd = 0;
        q1 = 0; r1 = 0; q2 = 0; r2 = 0;
        @(negedge clk);
        dif.i_start = 1'b1;
        dif.i_dvd   = 16'sd20;
        dif.i_dvs   = 8'sd3;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) begin
                dif.i_dvd = 16'sd100;
                dif.i_dvs = 8'sd7;
            end
            if (dif.o_busy === 1'b1) busy_n++;
            if (dif.o_done === 1'b1) begin
                nd++;
                if (d1 < 0) begin
                    d1 = k; q1 = int'(dif.o_quot); r1 = int'(dif.o_rem);
                end else if (d2 < 0) begin
                    d2 = k; q2 = int'(dif.o_quot); r2 = int'(dif.o_rem);
                end
            end
            if (k == 19) chk("held idle_at_19", int'(dif.o_busy), 0);
            if (k == 20) chk("held restart_busy", int'(dif.o_busy), 1);
            if (k == 37) dif.i_start = 1'b0;
        end
        chk("held first_done", d1, 18);
        chk("held first_quot", q1, 6);
        chk("held first_rem",  r1, 2);
        chk("held second_done", d2, 37);
        chk("held second_quot", q2, 14);
        chk("held second_rem",  r2, 2);
        chk("held done_pulses", nd, 2);
        chk("held busy_cycles", busy_n, 34);
        $display("held: first done@%0d %0d r%0d, second done@%0d %0d r%0d",
                 d1, q1, r1, d2, q2, r2);

        // Reset in cycle 9 of a division discards it.
        @(negedge clk);
        dif.i_start = 1'b1;
        dif.i_dvd   = 16'sd100;
        dif.i_dvs   = 8'sd7;
        @(posedge clk);
        #1;
        dif.i_start = 1'b0;
        for (int k = 1; k <= 9; k++) @(negedge clk);
        chk("midrst busy_before", int'(dif.o_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", int'(dif.o_busy), 0);
        chk("midrst done", int'(dif.o_done), 0);
        chk("midrst quot", int'(dif.o_quot), 0);
        chk("midrst rem",  int'(dif.o_rem), 0);
        chk("midrst ovf",  int'(dif.o_ovf), 0);
        chk("midrst dz",   int'(dif.o_dz), 0);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (dif.o_done === 1'b1 || dif.o_busy === 1'b1) nd++;
        end
        chk("midrst no_activity", nd, 0);
        $display("midrst: reset in cycle 9 checked");

        do_op("after_rst", 127, 1, 127, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
